// File: rtl/serializer_arbiter_pkg.sv
// Shared types and widths for the serializer front-end arbiter.
package serializer_arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  localparam int unsigned COUNT_W    = 6;
  localparam int unsigned WORD_BUS_W = 32 + 7 - 1;

endpackage

// File: rtl/serializer_arbiter_if.sv
// Word-source bus: per-source valid/ready handshake with packet framing and packed data.
interface serializer_arbiter_if
  import serializer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned WORD_BUS_W = serializer_arbiter_pkg::WORD_BUS_W
);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC-1:0]            src_first;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC*COUNT_W-1:0]    src_num_values;
  logic [NUM_SRC*WORD_BUS_W-1:0] src_word;

  modport master (
    output src_valid, src_first, src_last, src_num_values, src_word,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_first, src_last, src_num_values, src_word,
    output src_ready
  );

endinterface

// File: rtl/serializer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(ptr) + k) % NUM_SRC;
      if (!any && req[idx[ID_W-1:0]]) begin
        grant[idx[ID_W-1:0]] = 1'b1;
        id                   = idx[ID_W-1:0];
        any                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Packet-locking round-robin arbiter pacing word issue so the shared serializer runs gapless.
module serializer_arbiter
  import serializer_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned WORD_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 7,
  parameter  int unsigned ID_W       = $clog2(NUM_SRC),
  localparam int unsigned W          = WORD_WIDTH + DATA_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  serializer_arbiter_if.slave  src,
  output logic                 new_word_a,
  output logic                 first_word_a,
  output logic                 last_word_a,
  output logic [COUNT_W-1:0]   num_values_a,
  output logic [W-1:0]         word_a,
  output logic                 packet_in_progress,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 err_proto
);

  arb_state_t           state, state_nx;
  logic [ID_W-1:0]      owner, rr_ptr;
  logic [NUM_SRC-1:0]   owner_oh;
  logic [COUNT_W-1:0]   rem;

  logic [NUM_SRC-1:0]   first_req, grant_oh, stray;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any, grant_now;
  logic                 slot_open, own_xfer, own_first, own_last, issue, err_nx;
  logic [COUNT_W-1:0]   own_num;
  logic [W-1:0]         own_word;

  assign first_req = src.src_valid & src.src_first;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req   (first_req),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .id    (grant_idx),
    .any   (grant_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    own_first = src.src_first[owner];
    own_last  = src.src_last[owner];
    own_num   = src.src_num_values[owner*COUNT_W +: COUNT_W];
    own_word  = src.src_word[owner*W +: W];
    slot_open = (rem <= COUNT_W'(1));
    grant_now = (state == IDLE) && en && grant_any;
    stray     = '0;
    own_xfer  = 1'b0;
    if (state == IDLE) stray = src.src_valid & ~src.src_first;
    if (state == LOCKED) own_xfer = slot_open && src.src_valid[owner];
    issue  = own_xfer && (own_num != '0);
    err_nx = (own_xfer && (own_num == '0)) || (|stray);
    // Ready is held low during reset so stray words are not consumed before the arbiter runs.
    if (!rst_n)                  src.src_ready = '0;
    else if (state == LOCKED)    src.src_ready = owner_oh & {NUM_SRC{slot_open}};
    else                         src.src_ready = stray;
    case (state)
      IDLE:    if (grant_now) state_nx = LOCKED;
      LOCKED:  if (own_xfer && own_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner              <= '0;
      owner_oh           <= '0;
      rr_ptr             <= '0;
      rem                <= '0;
      new_word_a         <= 1'b0;
      first_word_a       <= 1'b0;
      last_word_a        <= 1'b0;
      num_values_a       <= '0;
      word_a             <= '0;
      packet_in_progress <= 1'b0;
      grant_id           <= '0;
      err_proto          <= 1'b0;
    end else begin
      if (grant_now) begin
        owner    <= grant_idx;
        owner_oh <= grant_oh;
        grant_id <= grant_idx;
      end
      if (own_xfer && own_last)
        rr_ptr <= (owner == ID_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
      new_word_a <= issue;
      if (issue) begin
        first_word_a <= own_first;
        last_word_a  <= own_last;
        num_values_a <= own_num;
        word_a       <= own_word;
      end
      // Reload on issue replaces the final decrement, so the next word lands on the last value cycle.
      if (issue)            rem <= own_num;
      else if (rem != '0)   rem <= rem - 1'b1;
      packet_in_progress <= (state_nx == LOCKED) || (issue && own_last);
      err_proto          <= err_nx;
    end
  end

  assign busy = (state == LOCKED) || (rem != '0);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Self-checking bench: vector table plus multi-cycle sequences, with an issue scoreboard.
module tb_serializer_arbiter;
  import serializer_arbiter_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned WB = 38;

  logic clk, rst_n, en;
  logic new_word_a, first_word_a, last_word_a, packet_in_progress, busy, err_proto;
  logic [5:0]    num_values_a;
  logic [WB-1:0] word_a;
  logic [1:0]    grant_id;

  serializer_arbiter_if #(.NUM_SRC(NS), .WORD_BUS_W(WB)) sif ();

  serializer_arbiter #(.NUM_SRC(NS), .WORD_WIDTH(32), .DATA_WIDTH(7)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .src                (sif.slave),
    .new_word_a         (new_word_a),
    .first_word_a       (first_word_a),
    .last_word_a        (last_word_a),
    .num_values_a       (num_values_a),
    .word_a             (word_a),
    .packet_in_progress (packet_in_progress),
    .grant_id           (grant_id),
    .busy               (busy),
    .err_proto          (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned   src;
    logic          f;
    logic          l;
    logic [5:0]    n;
    logic [WB-1:0] w;
  } wd_t;

  typedef struct {
    int unsigned src;
    logic        f;
    logic        l;
    logic [5:0]  n;
    int          exp_issue;
    int          exp_err;
    logic [1:0]  exp_gid;
  } vec_t;

  wd_t src_q[NS][$];
  wd_t exp_q[$];
  int  issue_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int issue_cnt = 0;
  logic [NS-1:0] hs, rdy_s;
  logic err_s, nw_s, pip_s, busy_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive();
    wd_t e;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        sif.src_valid[i]                = 1'b1;
        sif.src_first[i]                = e.f;
        sif.src_last[i]                 = e.l;
        sif.src_num_values[i*6 +: 6]    = e.n;
        sif.src_word[i*WB +: WB]        = e.w;
      end else begin
        sif.src_valid[i] = 1'b0;
        sif.src_first[i] = 1'b0;
        sif.src_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic add_word(input int unsigned s, input logic f, input logic l,
                          input logic [5:0] n, input logic iss);
    wd_t e;
    e.src = s; e.f = f; e.l = l; e.n = n;
    e.w   = {6'(s), 32'($urandom)};
    src_q[s].push_back(e);
    if (iss) exp_q.push_back(e);
  endtask

  // One clock: sample at negedge, score issues, then advance sources after the edge.
  task automatic cycle();
    wd_t e;
    @(negedge clk);
    cyc++;
    rdy_s  = sif.src_ready;
    err_s  = err_proto;
    nw_s   = new_word_a;
    pip_s  = packet_in_progress;
    busy_s = busy;
    hs     = sif.src_valid & sif.src_ready;
    if (err_proto) err_cnt++;
    if (new_word_a) begin
      issue_cnt++;
      issue_cyc.push_back(cyc);
      chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_word", 64'(word_a), 64'(e.w));
        chk("issue_flags", 64'({first_word_a, last_word_a, num_values_a}), 64'({e.f, e.l, e.n}));
        chk("issue_owner", 64'(grant_id), 64'(e.src));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  function automatic logic all_done();
    logic d;
    d = (exp_q.size() == 0) && !busy_s && !pip_s;
    for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(input int bound, input string tag);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!all_done() && k < bound);
    chk({tag, "_drain"}, 64'(all_done()), 64'd1);
    cycle();
    cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({new_word_a, first_word_a, last_word_a, packet_in_progress,
                              busy, err_proto, grant_id}), 64'd0);
    chk({tag, "_num"},   64'(num_values_a), 64'd0);
    chk({tag, "_word"},  64'(word_a), 64'd0);
    chk({tag, "_ready"}, 64'(sif.src_ready), 64'd0);
  endtask

  vec_t vecs[6];
  int   e0, i0, k;

  initial begin
    vecs[0] = '{src: 0, f: 1, l: 1, n: 6'd3,  exp_issue: 1, exp_err: 0, exp_gid: 2'd0};
    vecs[1] = '{src: 3, f: 1, l: 1, n: 6'd1,  exp_issue: 1, exp_err: 0, exp_gid: 2'd3};
    vecs[2] = '{src: 1, f: 1, l: 1, n: 6'd0,  exp_issue: 0, exp_err: 1, exp_gid: 2'd1};
    vecs[3] = '{src: 2, f: 0, l: 1, n: 6'd4,  exp_issue: 0, exp_err: 1, exp_gid: 2'd1};
    vecs[4] = '{src: 2, f: 1, l: 1, n: 6'd63, exp_issue: 1, exp_err: 0, exp_gid: 2'd2};
    vecs[5] = '{src: 1, f: 1, l: 1, n: 6'd2,  exp_issue: 1, exp_err: 0, exp_gid: 2'd1};

    rst_n = 1'b0;
    en    = 1'b1;
    sif.src_valid = '0; sif.src_first = '0; sif.src_last = '0;
    sif.src_num_values = '0; sif.src_word = '0;
    sif.src_valid[1] = 1'b1;
    #12;
    chk_zero("reset");
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    for (int v = 0; v < 6; v++) begin
      e0 = err_cnt;
      i0 = issue_cnt;
      add_word(vecs[v].src, vecs[v].f, vecs[v].l, vecs[v].n, 1'(vecs[v].exp_issue));
      drive();
      drain(150, "vec");
      chk("vec_err",   64'(err_cnt - e0),   64'(vecs[v].exp_err));
      chk("vec_issue", 64'(issue_cnt - i0), 64'(vecs[v].exp_issue));
      chk("vec_gid",   64'(grant_id),       64'(vecs[v].exp_gid));
    end

    issue_cyc.delete();
    add_word(0, 1, 0, 6'd5, 1);
    add_word(0, 0, 0, 6'd5, 1);
    add_word(0, 0, 1, 6'd4, 1);
    drive();
    drain(80, "three_word");
    chk("three_word_count", 64'(issue_cyc.size()), 64'd3);
    if (issue_cyc.size() == 3) begin
      chk("three_word_gap1", 64'(issue_cyc[1] - issue_cyc[0]), 64'd5);
      chk("three_word_gap2", 64'(issue_cyc[2] - issue_cyc[1]), 64'd5);
    end

    i0 = issue_cnt;
    add_word(1, 0, 0, 6'd2, 0);
    drive();
    cycle();
    chk("stray_ready", 64'(rdy_s[1]), 64'd1);
    cycle();
    chk("stray_err",     64'(err_s), 64'd1);
    chk("stray_noissue", 64'(issue_cnt - i0), 64'd0);

    i0 = issue_cnt;
    e0 = err_cnt;
    add_word(1, 1, 0, 6'd3, 1);
    add_word(1, 0, 1, 6'd0, 0);
    drive();
    k = 0;
    do begin cycle(); k++; end while (src_q[1].size() != 0 && k < 30);
    chk("zl_accepted", 64'(src_q[1].size()), 64'd0);
    cycle();
    chk("zl_err",   64'(err_s),  64'd1);
    chk("zl_pip",   64'(pip_s),  64'd0);
    chk("zl_busy",  64'(busy_s), 64'd0);
    chk("zl_issue", 64'(issue_cnt - i0), 64'd1);
    drain(20, "zl");

    i0 = issue_cnt;
    add_word(0, 1, 0, 6'd6, 1);
    add_word(0, 0, 1, 6'd6, 1);
    drive();
    k = 0;
    do begin cycle(); k++; end while (src_q[0].size() != 1 && k < 20);
    en = 1'b0;
    add_word(3, 1, 1, 6'd2, 1);
    drive();
    repeat (15) cycle();
    chk("en_w1_issued", 64'(issue_cnt - i0), 64'd2);
    chk("en_hold_pip",  64'(pip_s), 64'd0);
    chk("en_hold_src3", 64'(src_q[3].size()), 64'd1);
    chk("en_hold_gid",  64'(grant_id), 64'd0);
    en = 1'b1;
    drain(40, "en_resume");
    chk("en_resume_gid", 64'(grant_id), 64'd3);

    add_word(1, 1, 1, 6'd2, 1);
    drive();
    drain(20, "pre_rst");
    i0 = issue_cnt;
    add_word(2, 1, 0, 6'd8, 1);
    add_word(2, 0, 0, 6'd8, 1);
    add_word(2, 0, 1, 6'd8, 1);
    drive();
    k = 0;
    do begin cycle(); k++; end while ((issue_cnt - i0) < 2 && k < 60);
    chk("mid_rst_reached", 64'(issue_cnt - i0), 64'd2);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    exp_q.delete();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    drive();
    cycle();
    cycle();
    rst_n = 1'b1;

    add_word(0, 1, 0, 6'd3, 1);
    add_word(0, 0, 1, 6'd2, 1);
    add_word(2, 1, 0, 6'd4, 1);
    add_word(2, 0, 1, 6'd1, 1);
    drive();
    drain(60, "contend");
    chk("contend_last_gid", 64'(grant_id), 64'd2);

    add_word(3, 1, 1, 6'd2, 1);
    add_word(0, 1, 1, 6'd2, 1);
    drive();
    drain(40, "rotate");
    chk("rotate_last_gid", 64'(grant_id), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
